video_lcd_frame_sequencer: RTL and testbench

VIDEO_LCD_FRAME_SEQUENCER -- requirements
Module: video_lcd_frame_sequencer

---
 rtl/video_lcd_frame_sequencer.sv | 230 +++++++++++++++++++++++
 tb/tb_video_lcd_frame_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_lcd_frame_sequencer.sv
// LCD frame sequencer: bridges a CPU slave port onto an i80 bus bridge and,
// on command, streams a frame of pixels as a GRAM index write followed by
// one data write per pixel.
module video_lcd_frame_sequencer #(
    parameter logic [15:0] GRAM_INDEX = 16'h0022,
    parameter int unsigned COUNT_W    = 20
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_cpu_request,
    input  logic        i_cpu_rw,
    input  logic [1:0]  i_cpu_address,
    input  logic [31:0] i_cpu_wdata,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ready,
    input  logic        i_pix_valid,
    input  logic [15:0] i_pix_data,
    output logic        o_pix_ready,
    output logic        o_lcd_request,
    output logic        o_lcd_rw,
    output logic [1:0]  o_lcd_address,
    output logic [31:0] o_lcd_wdata,
    input  logic [31:0] i_lcd_rdata,
    input  logic        i_lcd_ready
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_FWD,
        CPU_ACK,
        IDX_WR,
        PIX_WAIT,
        PIX_WR,
        DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               cpuReady_q, cpuReady_d;
    logic [31:0]        cpuRdata_q, cpuRdata_d;
    logic               lcdReq_q, lcdReq_d;
    logic               lcdWait_q, lcdWait_d;
    logic               lcdRw_q, lcdRw_d;
    logic [1:0]         lcdAddr_q, lcdAddr_d;
    logic [31:0]        lcdWdata_q, lcdWdata_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               abort_q, abort_d;
    logic [COUNT_W-1:0] remaining_q, remaining_d;

    logic [31:0]        status;
    logic               cpuNew;
    logic               localHit;
    logic               fwdHit;
    logic               bridgeDone;
    logic               pixTake;
    logic [COUNT_W-1:0] cmdCount;
    logic [COUNT_W-1:0] remainingDec;

    // Status word and request decode shared by the next-state logic
    always_comb begin
        status                 = '0;
        status[31]             = busy_q;
        status[30]             = overrun_q;
        status[COUNT_W-1:0]    = remaining_q;
        cpuNew                 = i_cpu_request && !cpuReady_q;
        localHit               = cpuNew && i_cpu_address[1];
        fwdHit                 = cpuNew && !i_cpu_address[1];
        cmdCount               = i_cpu_wdata[COUNT_W-1:0];
        bridgeDone             = lcdWait_q && !i_lcd_ready;
        pixTake                = (state_q == PIX_WAIT) && i_pix_valid && !abort_q;
        remainingDec           = remaining_q - COUNT_W'(1);
    end

    // Next-state logic: bridge handshake, streaming FSM, then local register accesses
    always_comb begin
        state_d     = state_q;
        cpuReady_d  = cpuReady_q;
        cpuRdata_d  = cpuRdata_q;
        lcdReq_d    = lcdReq_q;
        lcdWait_d   = lcdWait_q;
        lcdRw_d     = lcdRw_q;
        lcdAddr_d   = lcdAddr_q;
        lcdWdata_d  = lcdWdata_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        abort_d     = abort_q;
        remaining_d = remaining_q;

        if (cpuReady_q && !i_cpu_request) begin
            cpuReady_d = 1'b0;
        end

        if (state_q inside {CPU_FWD, IDX_WR, PIX_WR}) begin
            if (lcdReq_q) begin
                if (i_lcd_ready) begin
                    lcdReq_d  = 1'b0;
                    lcdWait_d = 1'b1;
                end
            end else if (lcdWait_q) begin
                if (!i_lcd_ready) begin
                    lcdWait_d = 1'b0;
                end
            end else if (!i_lcd_ready) begin
                lcdReq_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (fwdHit) begin
                    state_d    = CPU_FWD;
                    lcdRw_d    = i_cpu_rw;
                    lcdAddr_d  = i_cpu_address;
                    lcdWdata_d = i_cpu_wdata;
                end
            end
            CPU_FWD: begin
                if (lcdReq_q && i_lcd_ready && !lcdRw_q) begin
                    cpuRdata_d = i_lcd_rdata;
                end
                if (bridgeDone) begin
                    cpuReady_d = 1'b1;
                    state_d    = CPU_ACK;
                end
            end
            CPU_ACK: begin
                if (!i_cpu_request) begin
                    state_d = IDLE;
                end
            end
            IDX_WR: begin
                if (bridgeDone) begin
                    state_d = abort_q ? DRAIN : PIX_WAIT;
                end
            end
            PIX_WAIT: begin
                if (abort_q) begin
                    state_d = DRAIN;
                end else if (pixTake) begin
                    state_d    = PIX_WR;
                    lcdRw_d    = 1'b1;
                    lcdAddr_d  = 2'd1;
                    lcdWdata_d = {16'h0000, i_pix_data};
                end
            end
            PIX_WR: begin
                if (bridgeDone) begin
                    remaining_d = remainingDec;
                    state_d     = ((remainingDec == '0) || abort_q) ? DRAIN : PIX_WAIT;
                end
            end
            DRAIN: begin
                if (!i_lcd_ready) begin
                    busy_d  = 1'b0;
                    abort_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (localHit) begin
            cpuReady_d = 1'b1;
            if (!i_cpu_rw) begin
                cpuRdata_d = status;
            end else if (!i_cpu_address[0]) begin
                if (busy_q) begin
                    overrun_d = 1'b1;
                end else if ((state_q == IDLE) && (cmdCount != '0)) begin
                    busy_d      = 1'b1;
                    abort_d     = 1'b0;
                    remaining_d = cmdCount;
                    state_d     = IDX_WR;
                    lcdRw_d     = 1'b1;
                    lcdAddr_d   = 2'd0;
                    lcdWdata_d  = {16'h0000, GRAM_INDEX};
                end
            end else begin
                if (i_cpu_wdata[1]) begin
                    overrun_d = 1'b0;
                end
                if (i_cpu_wdata[0] && busy_q) begin
                    abort_d = 1'b1;
                end
            end
        end
    end

    // State and output registers; reset discards any frame in progress
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            cpuReady_q  <= 1'b0;
            cpuRdata_q  <= '0;
            lcdReq_q    <= 1'b0;
            lcdWait_q   <= 1'b0;
            lcdRw_q     <= 1'b0;
            lcdAddr_q   <= '0;
            lcdWdata_q  <= '0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            cpuReady_q  <= cpuReady_d;
            cpuRdata_q  <= cpuRdata_d;
            lcdReq_q    <= lcdReq_d;
            lcdWait_q   <= lcdWait_d;
            lcdRw_q     <= lcdRw_d;
            lcdAddr_q   <= lcdAddr_d;
            lcdWdata_q  <= lcdWdata_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
            remaining_q <= remaining_d;
        end
    end

    assign o_cpu_ready   = cpuReady_q;
    assign o_cpu_rdata   = cpuRdata_q;
    assign o_pix_ready   = pixTake;
    assign o_lcd_request = lcdReq_q;
    assign o_lcd_rw      = lcdRw_q;
    assign o_lcd_address = lcdAddr_q;
    assign o_lcd_wdata   = lcdWdata_q;

endmodule

// File: tb/tb_video_lcd_frame_sequencer.sv
// Bench for the LCD frame sequencer: a bridge responder, a pixel source, a
// queue of expected bridge transactions and directed CPU scenarios.
module tb_video_lcd_frame_sequencer;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_cpu_request;
    logic        i_cpu_rw;
    logic [1:0]  i_cpu_address;
    logic [31:0] i_cpu_wdata;
    logic [31:0] o_cpu_rdata;
    logic        o_cpu_ready;
    logic        i_pix_valid;
    logic [15:0] i_pix_data;
    logic        o_pix_ready;
    logic        o_lcd_request;
    logic        o_lcd_rw;
    logic [1:0]  o_lcd_address;
    logic [31:0] o_lcd_wdata;
    logic [31:0] i_lcd_rdata;
    logic        i_lcd_ready;

    int          total = 0;
    int          bad = 0;
    int          txnCount = 0;
    int          dataCount = 0;
    int          pixTaken = 0;
    logic [31:0] bridgeRdata = 32'h0;
    logic [35:0] expQ[$];
    logic [15:0] pixQ[$];

    video_lcd_frame_sequencer #(
        .GRAM_INDEX (16'h0022),
        .COUNT_W    (20)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_cpu_request (i_cpu_request),
        .i_cpu_rw      (i_cpu_rw),
        .i_cpu_address (i_cpu_address),
        .i_cpu_wdata   (i_cpu_wdata),
        .o_cpu_rdata   (o_cpu_rdata),
        .o_cpu_ready   (o_cpu_ready),
        .i_pix_valid   (i_pix_valid),
        .i_pix_data    (i_pix_data),
        .o_pix_ready   (o_pix_ready),
        .o_lcd_request (o_lcd_request),
        .o_lcd_rw      (o_lcd_rw),
        .o_lcd_address (o_lcd_address),
        .o_lcd_wdata   (o_lcd_wdata),
        .i_lcd_rdata   (i_lcd_rdata),
        .i_lcd_ready   (i_lcd_ready)
    );

    // Free-running clock
    always #5 i_clock = ~i_clock;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
        end
    endtask

    // Expected bridge transaction: {optional, rw, address, wdata}
    function automatic logic [35:0] mk(input logic opt, input logic rw, input logic [1:0] a, input logic [31:0] d);
        return {opt, rw, a, d};
    endfunction

    // Status word built from the register meanings: busy, overrun, remaining count
    function automatic logic [31:0] expStatus(input bit b, input bit o, input int unsigned rem);
        logic [31:0] s;
        s = rem;
        if (b) s = s + 32'h8000_0000;
        if (o) s = s + 32'h4000_0000;
        return s;
    endfunction

    // Bridge responder: ready rises a few cycles after a request, falls after the request drops
    initial begin : bridgeModel
        logic req;
        int   lat;
        i_lcd_ready = 1'b0;
        i_lcd_rdata = 32'h0;
        lat = 2;
        forever begin
            @(negedge i_clock);
            req = o_lcd_request;
            @(posedge i_clock);
            #1;
            if (!i_reset) begin
                i_lcd_ready = 1'b0;
                lat = 2;
            end else if (req && !i_lcd_ready) begin
                if (lat == 0) begin
                    i_lcd_ready = 1'b1;
                    i_lcd_rdata = bridgeRdata;
                end else begin
                    lat--;
                end
            end else if (!req && i_lcd_ready) begin
                i_lcd_ready = 1'b0;
                lat = 2;
            end
        end
    end

    // Pixel source: presents the head of pixQ, pops it once it was accepted
    initial begin : pixelSource
        logic take;
        i_pix_valid = 1'b0;
        i_pix_data  = 16'h0;
        forever begin
            @(negedge i_clock);
            take = o_pix_ready && i_pix_valid && i_reset;
            @(posedge i_clock);
            #1;
            if (take && pixQ.size() > 0) begin
                void'(pixQ.pop_front());
                pixTaken++;
            end
            if (pixQ.size() > 0) begin
                i_pix_valid = 1'b1;
                i_pix_data  = pixQ[0];
            end else begin
                i_pix_valid = 1'b0;
            end
        end
    end

    // Per-cycle compare: bridge protocol rules and accepted transactions against expQ
    initial begin : compareProc
        logic        prevReq;
        logic [34:0] prevFields;
        logic [34:0] obs;
        logic [35:0] expv;
        prevReq    = 1'b0;
        prevFields = '0;
        forever begin
            @(negedge i_clock);
            obs = {o_lcd_rw, o_lcd_address, o_lcd_wdata};
            if (!i_reset) begin
                prevReq = 1'b0;
            end else begin
                if (o_lcd_request && !prevReq) checkOutput("request while bridge ready", i_lcd_ready, 0);
                if (o_lcd_request && prevReq) checkOutput("request fields stable", obs, prevFields);
                if (o_pix_ready) checkOutput("pix ready without valid", i_pix_valid, 1);
                if (o_lcd_request && i_lcd_ready) begin
                    txnCount++;
                    if (o_lcd_rw && o_lcd_address == 2'd1) dataCount++;
                    while (expQ.size() > 0 && expQ[0][35] && expQ[0][34:0] != obs) void'(expQ.pop_front());
                    if (expQ.size() > 0) expv = expQ.pop_front();
                    else expv = {1'b0, 35'h7_FFFF_FFFF};
                    checkOutput("bridge txn", obs, expv[34:0]);
                end
                prevReq    = o_lcd_request;
                prevFields = obs;
            end
        end
    end

    // One CPU access: raise request, wait for ack, drop request, ack must clear next cycle
    task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output int lat);
        @(posedge i_clock);
        #1;
        i_cpu_request = 1'b1;
        i_cpu_rw      = rw;
        i_cpu_address = addr;
        i_cpu_wdata   = wd;
        lat = 0;
        while (!o_cpu_ready && lat < 1000) begin
            @(posedge i_clock);
            #1;
            lat++;
        end
        checkOutput("cpu ack", o_cpu_ready, 1);
        rd = o_cpu_rdata;
        i_cpu_request = 1'b0;
        @(posedge i_clock);
        #1;
        checkOutput("cpu ready release", o_cpu_ready, 0);
    endtask

    // Poll status until the frame is over
    task automatic waitIdle();
        logic [31:0] rd;
        int          lat;
        int          polls;
        polls = 0;
        rd = 32'hFFFF_FFFF;
        while (rd[31] && polls < 100) begin
            applyStimulus(1'b0, 2'd2, 32'h0, rd, lat);
            polls++;
        end
        checkOutput("frame finished", rd[31], 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " cpu_ready"}, o_cpu_ready, 0);
        checkOutput({tag, " cpu_rdata"}, o_cpu_rdata, 0);
        checkOutput({tag, " pix_ready"}, o_pix_ready, 0);
        checkOutput({tag, " lcd_request"}, o_lcd_request, 0);
        checkOutput({tag, " lcd_rw"}, o_lcd_rw, 0);
        checkOutput({tag, " lcd_address"}, o_lcd_address, 0);
        checkOutput({tag, " lcd_wdata"}, o_lcd_wdata, 0);
    endtask

    // Watchdog so a stuck design still ends the run
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios
    initial begin : mainProc
        logic [31:0] rd;
        int          lat;
        int          t0;
        int          d0;
        int          p0;
        int          taken;
        int          cyc;
        bit          found;

        i_reset       = 1'b0;
        i_cpu_request = 1'b0;
        i_cpu_rw      = 1'b0;
        i_cpu_address = 2'd0;
        i_cpu_wdata   = 32'h0;
        repeat (3) @(posedge i_clock);
        #1;
        checkAllZero("reset");
        i_reset = 1'b1;

        applyStimulus(1'b0, 2'd3, 32'h0, rd, lat);
        checkOutput("status after reset", rd, 32'h0000_0000);
        checkOutput("status read latency", lat, 1);

        // Forwarded index write
        expQ.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_0022));
        t0 = txnCount;
        applyStimulus(1'b1, 2'd0, 32'h0000_0022, rd, lat);
        checkOutput("index write txns before ack", txnCount - t0, 1);
        checkOutput("index write queue drained", expQ.size(), 0);

        // Forwarded data read
        bridgeRdata = 32'h0000_1234;
        expQ.push_back(mk(1'b0, 1'b0, 2'd1, 32'h0));
        applyStimulus(1'b0, 2'd1, 32'h0, rd, lat);
        checkOutput("forwarded read data", rd, 32'h0000_1234);
        checkOutput("forwarded read queue drained", expQ.size(), 0);

        // Three-pixel frame
        pixQ.push_back(16'h00A1);
        pixQ.push_back(16'h00B2);
        pixQ.push_back(16'h00C3);
        expQ.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_0022));
        expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_00A1));
        expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_00B2));
        expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_00C3));
        applyStimulus(1'b1, 2'd2, 32'd3, rd, lat);
        checkOutput("frame command latency", lat, 1);
        waitIdle();
        checkOutput("frame3 queue drained", expQ.size(), 0);
        applyStimulus(1'b0, 2'd3, 32'h0, rd, lat);
        checkOutput("frame3 status", rd, expStatus(0, 0, 0));

        // Zero-length command
        t0 = txnCount;
        applyStimulus(1'b1, 2'd2, 32'd0, rd, lat);
        checkOutput("zero command latency", lat, 1);
        repeat (20) @(posedge i_clock);
        #1;
        checkOutput("zero command bridge txns", txnCount - t0, 0);
        applyStimulus(1'b0, 2'd2, 32'h0, rd, lat);
        checkOutput("zero command status", rd, expStatus(0, 0, 0));

        // Five-pixel frame with an overrun command and a stalled index write
        d0 = dataCount;
        expQ.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_0022));
        for (int i = 0; i < 5; i++) begin
            pixQ.push_back(16'h1100 + 16'(i));
            expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_1100 + i));
        end
        expQ.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_0033));
        applyStimulus(1'b1, 2'd2, 32'd5, rd, lat);
        applyStimulus(1'b1, 2'd2, 32'd7, rd, lat);
        checkOutput("overrun command latency", lat, 1);
        applyStimulus(1'b1, 2'd0, 32'h0000_0033, rd, lat);
        checkOutput("overrun frame pixel writes", dataCount - d0, 5);
        checkOutput("overrun queue drained", expQ.size(), 0);
        applyStimulus(1'b0, 2'd3, 32'h0, rd, lat);
        checkOutput("overrun status", rd, expStatus(0, 1, 0));
        checkOutput("overrun status literal", rd, 32'h4000_0000);
        applyStimulus(1'b1, 2'd3, 32'h2, rd, lat);
        applyStimulus(1'b0, 2'd2, 32'h0, rd, lat);
        checkOutput("overrun cleared", rd, expStatus(0, 0, 0));

        // Abort after two pixels of ten, then a data write
        d0 = dataCount;
        p0 = pixTaken;
        for (int i = 0; i < 10; i++) pixQ.push_back(16'hD000 + 16'(i));
        expQ.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_0022));
        expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_D000));
        expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_D001));
        expQ.push_back(mk(1'b1, 1'b1, 2'd1, 32'h0000_D002));
        expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_5555));
        applyStimulus(1'b1, 2'd2, 32'd10, rd, lat);
        cyc = 0;
        while ((dataCount - d0) < 2 && cyc < 1000) begin
            @(posedge i_clock);
            #1;
            cyc++;
        end
        checkOutput("abort point reached", (dataCount - d0) >= 2, 1);
        applyStimulus(1'b1, 2'd3, 32'h1, rd, lat);
        applyStimulus(1'b1, 2'd1, 32'h0000_5555, rd, lat);
        taken = pixTaken - p0;
        checkOutput("abort pixels taken 2 or 3", (taken == 2) || (taken == 3), 1);
        checkOutput("abort queue drained", expQ.size(), 0);
        applyStimulus(1'b0, 2'd3, 32'h0, rd, lat);
        checkOutput("abort status", rd, expStatus(0, 0, 10 - taken));
        pixQ.delete();

        // Reset in the middle of a pixel write
        for (int i = 0; i < 4; i++) begin
            pixQ.push_back(16'hE000 + 16'(i));
        end
        expQ.push_back(mk(1'b0, 1'b1, 2'd0, 32'h0000_0022));
        for (int i = 0; i < 4; i++) expQ.push_back(mk(1'b0, 1'b1, 2'd1, 32'h0000_E000 + i));
        applyStimulus(1'b1, 2'd2, 32'd4, rd, lat);
        found = 1'b0;
        cyc = 0;
        while (!found && cyc < 500) begin
            @(posedge i_clock);
            #1;
            cyc++;
            if (o_lcd_request && o_lcd_address == 2'd1) found = 1'b1;
        end
        checkOutput("pixel write seen before reset", found, 1);
        i_reset = 1'b0;
        #1;
        checkAllZero("mid-frame reset");
        expQ.delete();
        pixQ.delete();
        repeat (3) @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        t0 = txnCount;
        repeat (40) begin
            @(posedge i_clock);
            #1;
        end
        checkOutput("no txn after reset", txnCount - t0, 0);
        checkOutput("no request after reset", o_lcd_request, 0);
        applyStimulus(1'b0, 2'd3, 32'h0, rd, lat);
        checkOutput("status after mid-frame reset", rd, expStatus(0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
